// File: rtl/eth_dibit_feeder.sv
// Byte FIFO feeding an LSB-first dibit serializer for the Ethernet packer.
// Optional ETH_FEEDER_UNDERRUN_CANCEL_EN adds a one-cycle cancel pulse on underrun entry.
module eth_dibit_feeder #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  input  logic                       stall,
  output logic [1:0]                 axiod,
  output logic                       axiov,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [15:0]                underrun_count,
  output logic                       cancel_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shreg;
  logic [1:0]    idx;
  logic          loaded;

  logic wr_en;
  logic consume;
  logic pop;
  logic underrun;
  logic fifo_empty;

  // Handshake and serializer events, all decoded from registered state
  always_comb begin
    byte_ready = (fill < FW'(DEPTH));
    wr_en      = byte_valid && byte_ready && !rst;
    fifo_empty = (fill == '0);
    consume    = loaded && !stall;
    pop        = !fifo_empty && (!loaded || (consume && (idx == 2'd3)));
    underrun   = !stall && !loaded;
    axiod      = loaded ? shreg[1:0] : 2'b00;
    axiov      = loaded;
  end

  // Storage array carries no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Serializer: a pop on the last dibit reloads without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      idx    <= '0;
      loaded <= 1'b0;
    end else if (pop) begin
      shreg  <= mem[rd_ptr];
      idx    <= '0;
      loaded <= 1'b1;
    end else if (consume) begin
      shreg <= {2'b00, shreg[7:2]};
      idx   <= idx + 2'd1;
      if (idx == 2'd3) begin
        loaded <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

`ifdef ETH_FEEDER_UNDERRUN_CANCEL_EN
  logic prev_underrun;

  // Pulse only on the first cycle of an underrun run
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_underrun <= 1'b0;
      cancel_out    <= 1'b0;
    end else begin
      prev_underrun <= underrun;
      cancel_out    <= underrun && !prev_underrun;
    end
  end
`else
  assign cancel_out = 1'b0;
`endif

endmodule

// File: tb/tb_eth_dibit_feeder.sv
// Directed self-checking bench for eth_dibit_feeder (DEPTH=16).
module tb_eth_dibit_feeder;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        stall;
  logic [1:0]  axiod;
  logic        axiov;
  logic [4:0]  fill;
  logic [15:0] underrun_count;
  logic        cancel_out;

  int checks;
  int errors;

  eth_dibit_feeder #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .stall          (stall),
    .axiod          (axiod),
    .axiov          (axiov),
    .fill           (fill),
    .underrun_count (underrun_count),
    .cancel_out     (cancel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] exp8 [8];
  logic [7:0] b;
  int         acc;
  int         k;
  int         pulses;
  int         cyc;
  logic       exp_cancel;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    stall = 1'b0;
`ifdef ETH_FEEDER_UNDERRUN_CANCEL_EN
    exp_cancel = 1'b1;
`else
    exp_cancel = 1'b0;
`endif

    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_urun", 32'(underrun_count), 32'd0);
    chk("rst_cancel", 32'(cancel_out), 32'd0);

    // Single byte 8'hB4, LSB-first
    byte_valid = 1'b1; byte_data = 8'hB4;
    tick();
    byte_valid = 1'b0;
    chk("b4_fill1", 32'(fill), 32'd1);
    chk("b4_idle", 32'(axiov), 32'd0);
    tick();
    chk("b4_d0", 32'(axiod), 32'd0);
    chk("b4_v0", 32'(axiov), 32'd1);
    chk("b4_fill0", 32'(fill), 32'd0);
    tick();
    chk("b4_d1", 32'(axiod), 32'd1);
    tick();
    chk("b4_d2", 32'(axiod), 32'd3);
    tick();
    chk("b4_d3", 32'(axiod), 32'd2);
    chk("b4_v3", 32'(axiov), 32'd1);
    tick();
    chk("b4_vend", 32'(axiov), 32'd0);
    chk("b4_dend", 32'(axiod), 32'd0);

    // Back-to-back 8'h1B, 8'hE4 with no gap
    do_reset();
    exp8[0] = 2'b11; exp8[1] = 2'b10; exp8[2] = 2'b01; exp8[3] = 2'b00;
    exp8[4] = 2'b00; exp8[5] = 2'b01; exp8[6] = 2'b10; exp8[7] = 2'b11;
    byte_valid = 1'b1; byte_data = 8'h1B;
    tick();
    byte_data = 8'hE4;
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_d%0d", i), 32'(axiod), 32'(exp8[i]));
      chk($sformatf("b2b_v%0d", i), 32'(axiov), 32'd1);
      tick();
    end
    chk("b2b_vend", 32'(axiov), 32'd0);

    // Fill to capacity under stall
    do_reset();
    stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'(i);
      if (byte_ready) acc++;
      tick();
    end
    byte_valid = 1'b0;
    chk("full_acc", 32'(acc), 32'd17);
    chk("full_fill", 32'(fill), 32'd16);
    chk("full_ready", 32'(byte_ready), 32'd0);
    chk("full_head", 32'(axiod), 32'd0);
    stall = 1'b0;
    tick();
    tick();
    tick();
    chk("full_ready_pre", 32'(byte_ready), 32'd0);
    tick();
    chk("full_ready_post", 32'(byte_ready), 32'd1);
    chk("full_fill15", 32'(fill), 32'd15);
    chk("full_b1d0", 32'(axiod), 32'd1);

    // Empty feeder underrun
    stall = 1'b1;
    do_reset();
    stall = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("urun_d%0d", i), 32'(axiod), 32'd0);
      chk($sformatf("urun_v%0d", i), 32'(axiov), 32'd0);
      if (cancel_out) pulses++;
    end
    chk("urun_count", 32'(underrun_count), 32'd5);
    chk("urun_pulses", 32'(pulses), 32'(exp_cancel));

    // Reset mid-byte discards everything
    do_reset();
    byte_valid = 1'b1;
    byte_data = 8'hA5; tick();
    byte_data = 8'h3C; tick();
    byte_data = 8'h77; tick();
    chk("mid_d1", 32'(axiod), 32'd1);
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;
    tick();
    chk("mid_fill", 32'(fill), 32'd0);
    chk("mid_axiov", 32'(axiov), 32'd0);
    chk("mid_urun", 32'(underrun_count), 32'd0);
    chk("mid_ready", 32'(byte_ready), 32'd1);
    rst = 1'b0; byte_valid = 1'b0;
    tick();
    chk("mid_nowrite", 32'(fill), 32'd0);
    chk("mid_noload", 32'(axiov), 32'd0);
    byte_valid = 1'b1; byte_data = 8'h0F;
    tick();
    byte_valid = 1'b0;
    tick();
    chk("0f_d0", 32'(axiod), 32'd3);
    tick();
    chk("0f_d1", 32'(axiod), 32'd3);
    tick();
    chk("0f_d2", 32'(axiod), 32'd0);
    chk("0f_v2", 32'(axiov), 32'd1);
    tick();
    chk("0f_d3", 32'(axiod), 32'd0);
    chk("0f_v3", 32'(axiov), 32'd1);

    // Alternating stall over bytes 00..03
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_data = 8'(i);
      tick();
    end
    byte_valid = 1'b0;
    chk("tog_fill", 32'(fill), 32'd3);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 40) begin
      b = 8'(k / 4);
      b = b >> (2 * (k % 4));
      chk($sformatf("tog_d%0d_c%0d", k, cyc), 32'(axiod), 32'(b[1:0]));
      chk($sformatf("tog_v%0d_c%0d", k, cyc), 32'(axiov), 32'd1);
      stall = cyc[0];
      tick();
      if (!stall) k++;
      cyc++;
    end
    chk("tog_done", 32'(k), 32'd16);
    chk("tog_vend", 32'(axiov), 32'd0);
    chk("tog_fillend", 32'(fill), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
